// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared access-size codes, FSM states and fault check for the memory stage
package mem_access_stage_pkg;

   localparam logic [2:0] FNC_LB  = 3'b000;
   localparam logic [2:0] FNC_LH  = 3'b001;
   localparam logic [2:0] FNC_LW  = 3'b010;
   localparam logic [2:0] FNC_LBU = 3'b100;
   localparam logic [2:0] FNC_LHU = 3'b101;
   localparam logic [2:0] FNC_SB  = 3'b000;
   localparam logic [2:0] FNC_SH  = 3'b001;
   localparam logic [2:0] FNC_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_e;

   // Illegal size code or an address not aligned to the access size.
   function automatic logic is_fault(input logic [2:0] funct3, input logic [1:0] addr);
      logic f;
      f = 1'b1;
      case (funct3)
         FNC_LB, FNC_LBU: f = 1'b0;
         FNC_LH, FNC_LHU: f = addr[0];
         FNC_LW:          f = (addr != 2'b00);
         default:         f = 1'b1;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// rtl/mem_access_stage_load_align.sv - byte-lane extraction and sign/zero extension of a read word
module load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {addr, 3'b000};
      case (funct3)
         FNC_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         FNC_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
         FNC_LBU: data = {24'h0, shifted[7:0]};
         FNC_LHU: data = {16'h0, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - pipeline memory stage: ALU pass-through, load/store handshake with data memory
module mem_access_stage
   import mem_access_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic        ex_is_load,
   input  logic        ex_is_store,
   input  logic [2:0]  ex_funct3,
   input  logic [31:0] ex_alu_out,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        mem_fault,
   output logic        dmem_req,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_we,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   state_e      state_q, state_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        mem_fault_q, mem_fault_d;
   logic [31:0] addr_q, addr_d;
   logic [2:0]  f3_q, f3_d;
   logic [4:0]  rd_q, rd_d;
   logic        is_store_q, is_store_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] load_data;

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .addr   (addr_q[1:0]),
      .funct3 (f3_q),
      .data   (load_data)
   );

   always_comb begin
      state_d     = state_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      mem_fault_d = 1'b0;
      addr_d      = addr_q;
      f3_d        = f3_q;
      rd_d        = rd_q;
      is_store_d  = is_store_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (ex_valid) begin
               if (!ex_is_load && !ex_is_store) begin
                  wb_valid_d = 1'b1;
                  wb_rd_d    = ex_rd;
                  wb_data_d  = ex_alu_out;
               end else if (is_fault(ex_funct3, ex_alu_out[1:0])) begin
                  mem_fault_d = 1'b1;
               end else begin
                  addr_d     = ex_alu_out;
                  f3_d       = ex_funct3;
                  rd_d       = ex_rd;
                  is_store_d = ex_is_store;
                  we_d       = 4'b0000;
                  wdata_d    = ex_store_data;
                  // Store lanes are fixed here so the request outputs hold steady through REQ.
                  if (ex_is_store) begin
                     case (ex_funct3)
                        FNC_SB, FNC_LBU: begin
                           we_d    = 4'b0001 << ex_alu_out[1:0];
                           wdata_d = {4{ex_store_data[7:0]}};
                        end
                        FNC_SH, FNC_LHU: begin
                           we_d    = ex_alu_out[1] ? 4'b1100 : 4'b0011;
                           wdata_d = {2{ex_store_data[15:0]}};
                        end
                        FNC_SW:  we_d = 4'b1111;
                        default: we_d = 4'b0000;
                     endcase
                  end
                  state_d = ST_REQ;
               end
            end
         end
         ST_REQ: begin
            if (dmem_gnt) begin
               we_d    = 4'b0000;
               state_d = is_store_q ? ST_IDLE : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_data_d  = load_data;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= 5'd0;
         wb_data_q   <= 32'd0;
         mem_fault_q <= 1'b0;
         addr_q      <= 32'd0;
         f3_q        <= 3'd0;
         rd_q        <= 5'd0;
         is_store_q  <= 1'b0;
         we_q        <= 4'd0;
         wdata_q     <= 32'd0;
      end else begin
         state_q     <= state_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         mem_fault_q <= mem_fault_d;
         addr_q      <= addr_d;
         f3_q        <= f3_d;
         rd_q        <= rd_d;
         is_store_q  <= is_store_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
      end
   end

   assign stall      = (state_q != ST_IDLE);
   assign dmem_req   = (state_q == ST_REQ);
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_we    = we_q;
   assign dmem_wdata = wdata_q;
   assign wb_valid   = wb_valid_q;
   assign wb_rd      = wb_rd_q;
   assign wb_data    = wb_data_q;
   assign mem_fault  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed and streamed checks of mem_access_stage with a write-back scoreboard
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid = 1'b0, ex_is_load = 1'b0, ex_is_store = 1'b0;
   logic [2:0]  ex_funct3 = 3'd0;
   logic [31:0] ex_alu_out = 32'd0, ex_store_data = 32'd0;
   logic [4:0]  ex_rd = 5'd0;
   logic        stall, wb_valid, mem_fault, dmem_req;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data, dmem_addr, dmem_wdata;
   logic [3:0]  dmem_we;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;

   int n_cmp = 0;
   int n_fail = 0;
   int n_gnt = 0;
   int n_mem = 0;
   bit auto_mem = 1'b0;
   logic [36:0] exp_q[$];
   logic [31:0] mem [0:63];
   logic [31:0] ref_mem [0:63];

   mem_access_stage dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_load(ex_is_load),
      .ex_is_store(ex_is_store), .ex_funct3(ex_funct3), .ex_alu_out(ex_alu_out),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .stall(stall), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .mem_fault(mem_fault), .dmem_req(dmem_req),
      .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a, input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      h = a[1] ? w[31:16] : w[15:0];
      case (f3)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return w;
      endcase
   endfunction

   task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] sd);
      for (int i = 0; i < 4; i++) begin
         if (f3[1:0] == 2'b00) begin
            if (i == int'(a[1:0])) ref_mem[a[7:2]][8*i +: 8] = sd[7:0];
         end else if (f3[1:0] == 2'b01) begin
            if ((i / 2) == int'(a[1])) ref_mem[a[7:2]][8*i +: 8] = sd[8*(i%2) +: 8];
         end else begin
            ref_mem[a[7:2]][8*i +: 8] = sd[8*i +: 8];
         end
      end
   endtask

   // Holds the instruction on EX until the stage is idle, then lets one edge accept it.
   task automatic send(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
      int n;
      ex_valid = 1'b1; ex_is_load = ld; ex_is_store = st; ex_funct3 = f3;
      ex_alu_out = a; ex_store_data = sd; ex_rd = rd;
      n = 0;
      while (stall && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("stall_timeout", 32'(stall), 32'd0);
      @(negedge clk);
      ex_valid = 1'b0; ex_is_load = 1'b0; ex_is_store = 1'b0;
   endtask

   task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word,
                          input logic [4:0] rd, input logic [31:0] exp);
      exp_q.push_back({rd, exp});
      send(1'b1, 1'b0, f3, a, 32'd0, rd);
      chk("ld_req", 32'(dmem_req), 32'd1);
      chk("ld_addr", dmem_addr, {a[31:2], 2'b00});
      chk("ld_we", 32'(dmem_we), 32'd0);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("ld_wait_stall", 32'(stall), 32'd1);
      chk("ld_wait_req", 32'(dmem_req), 32'd0);
      dmem_rvalid = 1'b1; dmem_rdata = word;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("ld_wb_valid", 32'(wb_valid), 32'd1);
      chk("ld_stall_done", 32'(stall), 32'd0);
   endtask

   always @(negedge clk) begin
      if (rst_n && wb_valid) begin
         n_cmp++;
         assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL wb_extra: observed write-back rd=%0d data=%h expected none", wb_rd, wb_data);
         end
         if (exp_q.size() > 0) begin
            logic [36:0] e;
            e = exp_q.pop_front();
            chk("wb_rd", 32'(wb_rd), 32'(e[36:32]));
            chk("wb_data", wb_data, e[31:0]);
            chk("wb_with_fault", 32'(mem_fault), 32'd0);
         end
      end
   end

   initial begin : responder
      bit rd_pend;
      logic [5:0] rd_idx;
      rd_pend = 1'b0;
      rd_idx = 6'd0;
      forever begin
         @(negedge clk);
         if (auto_mem) begin
            dmem_gnt = 1'b0;
            dmem_rvalid = 1'b0;
            if (!rst_n) begin
               rd_pend = 1'b0;
            end else if (rd_pend) begin
               if ($urandom_range(0, 2) == 0) begin
                  dmem_rvalid = 1'b1;
                  dmem_rdata = mem[rd_idx];
                  rd_pend = 1'b0;
               end
            end else if (dmem_req && $urandom_range(0, 2) == 0) begin
               dmem_gnt = 1'b1;
               n_gnt++;
               if (dmem_we != 4'd0) begin
                  for (int i = 0; i < 4; i++)
                     if (dmem_we[i]) mem[dmem_addr[7:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
               end else begin
                  rd_pend = 1'b1;
                  rd_idx = dmem_addr[7:2];
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      repeat (3) @(negedge clk);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_fault", 32'(mem_fault), 32'd0);
      chk("rst_req", 32'(dmem_req), 32'd0);
      chk("rst_we", 32'(dmem_we), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_addr", dmem_addr, 32'd0);
      chk("rst_wdata", dmem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      exp_q.push_back({5'd5, 32'h0000_1234});
      send(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 5'd5);
      chk("alu_wb_valid", 32'(wb_valid), 32'd1);
      chk("alu_stall", 32'(stall), 32'd0);

      send(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd0);
      for (int k = 0; k < 4; k++) begin
         chk("sb_req", 32'(dmem_req), 32'd1);
         chk("sb_addr", dmem_addr, 32'h0000_1000);
         chk("sb_we", 32'(dmem_we), 32'b1000);
         chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
         if (k == 3) dmem_gnt = 1'b1;
         @(negedge clk);
      end
      dmem_gnt = 1'b0;
      chk("sb_done_stall", 32'(stall), 32'd0);
      chk("sb_done_req", 32'(dmem_req), 32'd0);
      chk("sb_no_wb", 32'(wb_valid), 32'd0);

      do_load(3'b000, 32'h0000_2002, 32'h0080_0000, 5'd7, 32'hFFFF_FF80);
      do_load(3'b100, 32'h0000_2002, 32'h0080_0000, 5'd8, 32'h0000_0080);
      do_load(3'b001, 32'h0000_2002, 32'h8001_0000, 5'd11, 32'hFFFF_8001);
      do_load(3'b101, 32'h0000_2002, 32'h8001_0000, 5'd12, 32'h0000_8001);

      send(1'b1, 1'b0, 3'b001, 32'h0000_3001, 32'd0, 5'd3);
      chk("lh_fault", 32'(mem_fault), 32'd1);
      chk("lh_fault_req", 32'(dmem_req), 32'd0);
      chk("lh_fault_stall", 32'(stall), 32'd0);
      chk("lh_fault_wb", 32'(wb_valid), 32'd0);
      @(negedge clk);
      chk("fault_pulse", 32'(mem_fault), 32'd0);
      send(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'd0, 5'd3);
      chk("f3_011_fault", 32'(mem_fault), 32'd1);
      send(1'b0, 1'b1, 3'b010, 32'h0000_3002, 32'd0, 5'd0);
      chk("sw_fault", 32'(mem_fault), 32'd1);
      chk("sw_fault_req", 32'(dmem_req), 32'd0);

      send(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'd0, 5'd9);
      chk("abort_req_pre", 32'(dmem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_req_async", 32'(dmem_req), 32'd0);
      chk("abort_stall_async", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'd0, 5'd9);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("abort_wait_stall", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_wait_async", 32'(stall), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("abort_no_wb", 32'(wb_valid), 32'd0);
      do_load(3'b010, 32'h0000_0048, 32'hDEAD_BEEF, 5'd10, 32'hDEAD_BEEF);

      auto_mem = 1'b1;
      for (int i = 0; i < 40; i++) begin
         int kind, sel;
         logic [2:0]  f3;
         logic [31:0] a, sd;
         logic [4:0]  rd;
         kind = $urandom_range(0, 2);
         sel = $urandom_range(0, 4);
         rd = 5'($urandom_range(1, 31));
         a = 32'($urandom_range(0, 255));
         sd = $urandom;
         if (kind == 0) begin
            exp_q.push_back({rd, sd});
            send(1'b0, 1'b0, 3'b000, sd, 32'd0, rd);
         end else begin
            if (kind == 2) sel = sel % 3;
            case (sel)
               0:       f3 = 3'b000;
               1:       f3 = 3'b001;
               2:       f3 = 3'b010;
               3:       f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3 == 3'b010) a[1:0] = 2'b00;
            n_mem++;
            if (kind == 1) begin
               exp_q.push_back({rd, ref_load(ref_mem[a[7:2]], a[1:0], f3)});
               send(1'b1, 1'b0, f3, a, 32'd0, rd);
            end else begin
               ref_store(f3, a, sd);
               send(1'b0, 1'b1, f3, a, sd, rd);
            end
         end
      end
      n = 0;
      while ((exp_q.size() != 0 || stall) && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("stream_drain", 32'(exp_q.size()), 32'd0);
      chk("stream_gnt_count", 32'(n_gnt), 32'(n_mem));
      auto_mem = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
